rcv_fifo_stream: RTL and testbench
==================================

// Module: rcv_fifo_stream
// PURPOSE
//   Parametrised receive buffer between the serial receive interface and the top-level read path.
//   It stores in-house register storage and needs no vendor FIFO core.
//   One word is accepted per rising edge of the receiver "ready" level (en_rcv), unless err or full is set.
//   The read side is first-word-fall-through with a valid/ready handshake.
//   Fill level, almost-full, and saturating overflow/error statistics go to the host status path.
// PARAMETERS
//   DW     8   data word width
//   DEPTH  16  storage depth in words; power of two, >=2
//   AFULL  12  almost_full asserts when level >= AFULL; range 1..DEPTH
//   SW     8   width of each statistics counter
//   (LW = $clog2(DEPTH+1) is derived, not overridable)
// PORTS
//   clk          in   1    single clock; all logic on posedge
//   rst          in   1    synchronous reset, active-high
//   din          in   DW   received word from receive interface
//   en_rcv       in   1    receiver ready level; rising edge marks a new word on din
//   err          in   1    receiver error, sampled in the same cycle as the en_rcv rising edge
//   flush        in   1    synchronous clear of stored data; statistics are kept
//   clr_stats    in   1    synchronous clear of ovf_cnt and err_cnt
//   hold         in   1    1 = stall the read side (dout_valid forced 0)
//   rd_ready     in   1    consumer accepts dout this cycle
//   dout         out  DW   head-of-queue word; 0 when empty
//   dout_valid   out  1    ~empty & ~hold
//   empty        out  1    level == 0
//   full         out  1    level == DEPTH
//   almost_full  out  1    level >= AFULL
//   level        out  LW   words stored
//   ovf_cnt      out  SW   words dropped because the buffer was full (saturating)
//   err_cnt      out  SW   words dropped because err was set (saturating)
// BEHAVIOUR
//   Reset values: dout=0, dout_valid=0, empty=1, full=0, almost_full=0, level=0, ovf_cnt=0, err_cnt=0.
//     Read/write pointers = 0. The en_rcv delay register resets to 1.
//     As a result, en_rcv held high through reset release does NOT create a write.
//   Edge detect: stb = en_rcv & ~en_rcv_q; en_rcv_q <= en_rcv every cycle.
//     A high level lasting several cycles produces exactly one stb.
//   pop  = dout_valid & rd_ready.
//   push = stb & ~err & (~full | pop).
//     A full buffer popped in the same cycle still accepts the push; level is unchanged.
//   stb & err                -> word dropped, err_cnt++ (err takes priority over the overflow check).
//   stb & ~err & full & ~pop -> word dropped, ovf_cnt++.
//   Counters saturate at 2^SW-1. clr_stats zeroes both; a clr_stats and an increment in the same cycle -> 0.
//   Pointers are LW-1 bits wide and wrap modulo DEPTH with no special case.
//     level += push - pop; it never exceeds DEPTH and never underflows.
//   Write latency: word pushed on edge N is visible on dout with dout_valid=1 after edge N+1.
//     A push into an empty buffer is never popped in the same cycle.
//   dout = mem[rd_ptr] combinationally while ~empty; dout changes only on a pop or on a push into an empty buffer.
//   Status flags (empty, full, almost_full, level) are registered and consistent with level after each edge.
//   flush: pointers and level -> 0 next edge; a push or pop in the same cycle is ignored.
//     A stb coinciding with flush is dropped and not counted.
//   Precedence: rst > flush > normal operation. clr_stats is independent of flush.
//   hold only gates dout_valid, so no pop can occur during hold; writes continue and can overflow.
//   rst mid-operation: all state returns to reset values on the next edge; buffered data is lost.
// TESTING
//   1 Reset with en_rcv=1, then keep en_rcv high 5 cycles -> no push; level=0, empty=1.
//   2 Write 0x11,0x22,0x33 (one en_rcv pulse each), rd_ready=1 -> dout 0x11,0x22,0x33 in order;
//     each visible 1 cycle after its stb; level returns to 0.
//   3 DEPTH=16, hold=1: write 18 words -> full=1, almost_full=1 from level 12, ovf_cnt=2;
//     release hold -> first 16 words read back, wrapping the pointers.
//   4 Full buffer, stb with rd_ready=1, hold=0 in the same cycle -> push accepted; level stays 16, ovf_cnt unchanged.
//   5 Three stb with err=1 -> err_cnt=3, level=0. SW=2: five err strobes -> err_cnt saturates at 3.
//     clr_stats -> err_cnt=0.
//   6 Level=7, then flush together with a stb -> level=0, empty=1, counters unchanged;
//     the next write is read back as the first word.

Source files
------------

// File: rtl/rcv_fifo_stream.sv
// Receive buffer: edge-triggered writes from the serial receiver, FWFT read side
// with valid/ready handshake, fill-level flags and saturating drop statistics.
module rcv_fifo_stream #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  parameter  int AFULL = 12,
  parameter  int SW    = 8,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] din_i,
  input  logic          en_rcv_i,
  input  logic          err_i,
  input  logic          flush_i,
  input  logic          clr_stats_i,
  input  logic          hold_i,
  input  logic          rd_ready_i,
  output logic [DW-1:0] dout_o,
  output logic          dout_valid_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          almost_full_o,
  output logic [LW-1:0] level_o,
  output logic [SW-1:0] ovf_cnt_o,
  output logic [SW-1:0] err_cnt_o
);

  localparam int PW = LW - 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          en_rcv_q;
  logic [SW-1:0] ovf_q, ovf_d;
  logic [SW-1:0] err_q, err_d;

  logic stb, pop, push, drop_err, drop_ovf, wr_en;

  assign stb          = en_rcv_i & ~en_rcv_q;
  assign dout_valid_o = ~empty_q & ~hold_i;
  assign pop          = dout_valid_o & rd_ready_i;
  // A full buffer being drained this cycle frees the slot the push needs.
  assign push         = stb & ~err_i & (~full_q | pop);
  assign drop_err     = stb & err_i & ~flush_i;
  assign drop_ovf     = stb & ~err_i & full_q & ~pop & ~flush_i;
  assign wr_en        = push & ~flush_i & ~rst_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(DEPTH));
    afull_d = (level_d >= LW'(AFULL));
  end

  always_comb begin
    ovf_d = ovf_q;
    err_d = err_q;
    if (clr_stats_i) begin
      ovf_d = '0;
      err_d = '0;
    end else begin
      if (drop_ovf && ovf_q != '1) ovf_d = ovf_q + SW'(1);
      if (drop_err && err_q != '1) err_d = err_q + SW'(1);
    end
  end

  // en_rcv_q resets high so a level already asserted at reset release is not a new word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      en_rcv_q <= 1'b1;
      ovf_q    <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      en_rcv_q <= en_rcv_i;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o        = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign level_o       = level_q;
  assign ovf_cnt_o     = ovf_q;
  assign err_cnt_o     = err_q;

endmodule

// File: tb/tb_rcv_fifo_stream.sv
// Bench for rcv_fifo_stream: scoreboard of accepted words checked against every pop,
// a cycle model of level/flags/statistics, and directed boundary checks.
module tb_rcv_fifo_stream;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int SW    = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, en_rcv, err, flush, clr_stats, hold, rd_ready;
  logic [DW-1:0] din;
  logic [DW-1:0] dout, dout2;
  logic          dout_valid, empty, full, almost_full;
  logic          dout_valid2, empty2, full2, almost_full2;
  logic [LW-1:0] level, level2;
  logic [SW-1:0] ovf_cnt, err_cnt;
  logic [1:0]    ovf_cnt2, err_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] sb [$];
  logic          m_prev_en, m_stb, m_pop, m_valid, m_was_full;
  int            m_ovf, m_err;

  always #5 clk = ~clk;

  rcv_fifo_stream #(.DW(DW), .DEPTH(DEPTH), .AFULL(AFULL), .SW(SW)) u_dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .en_rcv_i(en_rcv), .err_i(err),
    .flush_i(flush), .clr_stats_i(clr_stats), .hold_i(hold), .rd_ready_i(rd_ready),
    .dout_o(dout), .dout_valid_o(dout_valid), .empty_o(empty), .full_o(full),
    .almost_full_o(almost_full), .level_o(level), .ovf_cnt_o(ovf_cnt), .err_cnt_o(err_cnt)
  );

  // Narrow-statistics instance sharing all stimulus; only its counters are checked.
  rcv_fifo_stream #(.DW(DW), .DEPTH(DEPTH), .AFULL(AFULL), .SW(2)) u_dut_sw2 (
    .clk_i(clk), .rst_i(rst), .din_i(din), .en_rcv_i(en_rcv), .err_i(err),
    .flush_i(flush), .clr_stats_i(clr_stats), .hold_i(hold), .rd_ready_i(rd_ready),
    .dout_o(dout2), .dout_valid_o(dout_valid2), .empty_o(empty2), .full_o(full2),
    .almost_full_o(almost_full2), .level_o(level2), .ovf_cnt_o(ovf_cnt2), .err_cnt_o(err_cnt2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input logic e);
    cyc();
    din    = d;
    en_rcv = 1'b1;
    err    = e;
    cyc();
    en_rcv = 1'b0;
    err    = 1'b0;
  endtask

  task automatic pulse_clr();
    cyc();
    clr_stats = 1'b1;
    cyc();
    clr_stats = 1'b0;
  endtask

  // Cycle model: compares state after the previous edge, then predicts the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_prev_en = 1'b1;
      m_ovf     = 0;
      m_err     = 0;
    end else begin
      m_stb   = en_rcv && !m_prev_en;
      m_valid = (sb.size() != 0) && !hold;
      m_pop   = m_valid && rd_ready;
      check_eq("level", level, sb.size());
      check_eq("empty", empty, sb.size() == 0);
      check_eq("full", full, sb.size() == DEPTH);
      check_eq("almost_full", almost_full, sb.size() >= AFULL);
      check_eq("dout_valid", dout_valid, m_valid);
      check_eq("ovf_cnt", ovf_cnt, m_ovf);
      check_eq("err_cnt", err_cnt, m_err);
      if (sb.size() != 0) check_eq("dout", dout, sb[0]);
      else                check_eq("dout_when_empty", dout, 0);
      if (flush) begin
        sb.delete();
      end else begin
        m_was_full = (sb.size() == DEPTH);
        if (m_pop) void'(sb.pop_front());
        if (m_stb) begin
          if (err) begin
            if (m_err < 255) m_err++;
          end else if (m_was_full && !m_pop) begin
            if (m_ovf < 255) m_ovf++;
          end else begin
            sb.push_back(din);
          end
        end
      end
      if (clr_stats) begin
        m_ovf = 0;
        m_err = 0;
      end
      m_prev_en = en_rcv;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en_rcv = 1'b1; err = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    hold = 1'b0; rd_ready = 1'b0; din = '0;

    // reset with receiver level held high
    repeat (3) cyc();
    rst = 1'b0;
    check_eq("rst_level", level, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_afull", almost_full, 0);
    check_eq("rst_valid", dout_valid, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_ovf", ovf_cnt, 0);
    check_eq("rst_err", err_cnt, 0);
    repeat (5) cyc();
    check_eq("t1_level", level, 0);
    check_eq("t1_empty", empty, 1);
    en_rcv = 1'b0;
    cyc();

    // in-order pass-through with one-cycle latency
    rd_ready = 1'b1;
    write_word(8'h11, 1'b0);
    check_eq("t2_valid", dout_valid, 1);
    check_eq("t2_dout0", dout, 8'h11);
    write_word(8'h22, 1'b0);
    check_eq("t2_dout1", dout, 8'h22);
    write_word(8'h33, 1'b0);
    check_eq("t2_dout2", dout, 8'h33);
    cyc();
    check_eq("t2_level", level, 0);

    // fill under hold, overflow, almost_full threshold
    hold = 1'b1;
    for (int i = 0; i < 18; i++) begin
      write_word(DW'(i + 1), 1'b0);
      if (i == AFULL - 2) check_eq("t3_afull_below", almost_full, 0);
      if (i == AFULL - 1) check_eq("t3_afull_at", almost_full, 1);
    end
    check_eq("t3_full", full, 1);
    check_eq("t3_level", level, DEPTH);
    check_eq("t3_ovf", ovf_cnt, 2);
    check_eq("t3_hold_valid", dout_valid, 0);
    check_eq("t3_head", dout, 8'h01);

    // full buffer: simultaneous pop and push
    cyc();
    hold = 1'b0; din = 8'h77; en_rcv = 1'b1;
    cyc();
    hold = 1'b1; en_rcv = 1'b0;
    check_eq("t4_level", level, DEPTH);
    check_eq("t4_ovf", ovf_cnt, 2);
    check_eq("t4_head", dout, 8'h02);
    hold = 1'b0;
    for (int k = 0; k < 40 && !empty; k++) cyc();
    check_eq("t3_drained", empty, 1);

    // error strobes and saturation
    pulse_clr();
    check_eq("t5_ovf_clr", ovf_cnt, 0);
    for (int i = 0; i < 3; i++) write_word(8'hE0, 1'b1);
    check_eq("t5_err3", err_cnt, 3);
    check_eq("t5_err3_sw2", err_cnt2, 3);
    check_eq("t5_level", level, 0);
    for (int i = 0; i < 2; i++) write_word(8'hE1, 1'b1);
    check_eq("t5_err5", err_cnt, 5);
    check_eq("t5_sat_sw2", err_cnt2, 3);
    pulse_clr();
    check_eq("t5_clr", err_cnt, 0);
    check_eq("t5_clr_sw2", err_cnt2, 0);
    cyc();
    clr_stats = 1'b1; din = 8'hE2; en_rcv = 1'b1; err = 1'b1;
    cyc();
    clr_stats = 1'b0; en_rcv = 1'b0; err = 1'b0;
    check_eq("t5_clr_inc", err_cnt, 0);

    // flush coinciding with a strobe
    rd_ready = 1'b0;
    for (int i = 0; i < 7; i++) write_word(DW'(8'h60 + i), 1'b0);
    check_eq("t6_level7", level, 7);
    cyc();
    flush = 1'b1; din = 8'hEE; en_rcv = 1'b1;
    cyc();
    flush = 1'b0; en_rcv = 1'b0;
    check_eq("t6_level0", level, 0);
    check_eq("t6_empty", empty, 1);
    check_eq("t6_ovf", ovf_cnt, 0);
    check_eq("t6_err", err_cnt, 0);
    write_word(8'hA5, 1'b0);
    check_eq("t6_first", dout, 8'hA5);
    check_eq("t6_valid", dout_valid, 1);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    check_eq("t6_empty_after", empty, 1);
    check_eq("t6_sb_empty", sb.size(), 0);

    // reset mid-operation
    for (int i = 0; i < 3; i++) write_word(DW'(8'h90 + i), 1'b0);
    check_eq("rst2_pre", level, 3);
    cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    check_eq("rst2_level", level, 0);
    check_eq("rst2_empty", empty, 1);
    check_eq("rst2_dout", dout, 0);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
